alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits (legal 4..64).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount bits taken from b[SHW-1:0].
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand set a/b/op is valid.
REQ-006 SHALL have port in_ready  output  1  block accepts operand set this cycle.
REQ-007 SHALL have ports a, b  input  WIDTH  operands, unsigned or two's complement per op.
REQ-008 SHALL have port op  input  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 ACC, 7 CLRACC.
REQ-009 SHALL have port out_valid  output  1  result/flags are valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-011 SHALL have port result  output  WIDTH+1  result; MSB is carry/borrow/shifted-out bit, 0 for logic ops.
REQ-012 SHALL have port zero  output  1  result[WIDTH-1:0] == 0.
REQ-013 SHALL have port error  output  1  signed overflow of this result (ADD, SUB, ACC only).
REQ-014 SHALL have port error_sticky  output  1  OR of all error since reset or last clr_err.
REQ-015 SHALL have port clr_err  input  1  synchronous clear of error_sticky.

Function
REQ-016 Transfer on input side SHALL occur iff in_valid && in_ready; on output side iff out_valid && out_ready.
REQ-017 Pipeline SHALL be two registered stages: S1 (operand register), S2 (result register); accepted set appears on out_valid exactly 2 cycles after acceptance when out_ready held high.
REQ-018 Each stage SHALL advance when empty or when its downstream transfers; in_ready = !S1_valid || S1 advances (combinational from out_ready allowed).
REQ-019 Under continuous in_valid and out_ready throughput SHALL be one result per cycle; order SHALL be preserved; no set lost or duplicated under any backpressure pattern.
REQ-020 result/zero/error SHALL hold stable while out_valid && !out_ready.
REQ-021 ADD: result = a + b zero-extended to WIDTH+1; error = signs of a,b equal and differ from sum sign.
REQ-022 SUB: result = a - b modulo 2^(WIDTH+1) (MSB = borrow); error = signs of a,b differ and sum sign differs from a.
REQ-023 SHL: result = {a,1'b0...} shifted left by b[SHW-1:0], truncated to WIDTH+1 bits; shift amount >= WIDTH gives 0 in low bits.
REQ-024 Block SHALL hold internal accumulator acc (WIDTH bits, reset 0).
REQ-025 ACC: acc <= acc + a (wraps); result = {carry, new acc}; error per ADD rule on (acc, a).
REQ-026 CLRACC: acc <= 0; result = 0, zero = 1, error = 0.
REQ-027 acc SHALL update only on the cycle the ACC/CLRACC set loads into S2, so stalls never double-count; back-to-back ACC ops SHALL see the previous ACC's update.
REQ-028 error_sticky SHALL set on the cycle an error=1 result loads into S2; clr_err in the same cycle SHALL lose to a new error (set wins).

Reset
REQ-029 While rst_n = 0 all state SHALL clear asynchronously: S1/S2 valid 0, acc 0, result 0, zero 0, error 0, error_sticky 0.
REQ-030 in_ready SHALL be 1 in the first cycle after rst_n deasserts; reset mid-operation SHALL discard in-flight sets with no output transfer.

Structure
REQ-031 Opcode enum (op_t, 3 bits) and opcode constants SHALL live in shared package alu_pkg.
REQ-032 Combinational datapath SHALL be sub-module alu_core (a, b, op, acc -> result, error); alu_pipe owns handshake, registers and acc.

Verification (WIDTH=16)
REQ-033 Reset: rst_n low mid-stream -> out_valid 0, result 0, error_sticky 0; after release in_ready 1, no stale result appears.
REQ-034 ADD a=1 b=1, out_ready=1 -> 2 cycles later out_valid=1, result=17'h00002, zero=0, error=0.
REQ-035 ADD a=16'h7FFF b=1 -> result=17'h08000, error=1, error_sticky=1; ADD a=16'hFFFF b=1 -> result=17'h10000, zero=1, error=0; clr_err -> error_sticky=0.
REQ-036 Backpressure: three ADDs (1+1,2+2,3+3), out_ready low 5 cycles -> in_ready drops after two held, then results 2,4,6 in order, one per cycle once out_ready high.
REQ-037 Accumulator: CLRACC, ACC a=5, ACC a=7 with out_ready toggling 1/0 -> results 0,5,12; acc=12, no double count.
REQ-038 SHL a=16'h8001 b=1 -> result=17'h10002; b=16 -> low 16 bits 0, zero=1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the pipelined ALU.
//   op_t        : 3-bit opcode enumeration used on the op port and inside the pipe
//   add_ovf()   : two's-complement overflow rule for an addition
package alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD    = 3'd0,
    OP_SUB    = 3'd1,
    OP_AND    = 3'd2,
    OP_OR     = 3'd3,
    OP_XOR    = 3'd4,
    OP_SHL    = 3'd5,
    OP_ACC    = 3'd6,
    OP_CLRACC = 3'd7
  } op_t;

  // Signed overflow of x + y: operands agree in sign and the sum does not.
  function automatic logic add_ovf(input logic sign_x, input logic sign_y,
                                   input logic sign_sum);
    return (sign_x == sign_y) && (sign_sum != sign_x);
  endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core -- purely combinational ALU datapath.
//   a, b      : operands (WIDTH)
//   op        : operation (op_t)
//   acc       : current accumulator value (WIDTH)
//   result    : WIDTH+1 result, MSB = carry / borrow / shifted-out bit
//   error     : signed overflow for ADD, SUB and ACC
//   acc_load  : op updates the accumulator
//   acc_next  : new accumulator value when acc_load is set
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_t              op,
  input  logic [WIDTH-1:0] acc,
  output logic [WIDTH:0]   result,
  output logic             error,
  output logic             acc_load,
  output logic [WIDTH-1:0] acc_next
);

  localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic [WIDTH:0] acc_sum;
  logic [WIDTH:0] shl_lo;
  logic [WIDTH:0] shl;
  logic           oversize;

  always_comb begin
    sum     = {1'b0, a} + {1'b0, b};
    diff    = {1'b0, a} - {1'b0, b};
    acc_sum = {1'b0, acc} + {1'b0, a};

    // In-range shifts use the low SHW bits of b. Any set bit above them means
    // the amount is at least WIDTH, so every low bit is shifted out; only an
    // amount of exactly WIDTH leaves a[0] in the carry position.
    oversize = |(b >> SHW);
    shl_lo   = {1'b0, a} << b[SHW-1:0];
    shl      = oversize ? {(b == W_VAL) & a[0], {WIDTH{1'b0}}} : shl_lo;

    result   = '0;
    error    = 1'b0;
    acc_load = 1'b0;
    acc_next = acc;

    case (op)
      OP_ADD: begin
        result = sum;
        error  = add_ovf(a[WIDTH-1], b[WIDTH-1], sum[WIDTH-1]);
      end
      OP_SUB: begin
        result = diff;
        // a - b overflows when signs differ and the difference flips away from a.
        error  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: result = {1'b0, a & b};
      OP_OR:  result = {1'b0, a | b};
      OP_XOR: result = {1'b0, a ^ b};
      OP_SHL: result = shl;
      OP_ACC: begin
        result   = acc_sum;
        error    = add_ovf(acc[WIDTH-1], a[WIDTH-1], acc_sum[WIDTH-1]);
        acc_load = 1'b1;
        acc_next = acc_sum[WIDTH-1:0];
      end
      OP_CLRACC: begin
        acc_load = 1'b1;
        acc_next = '0;
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe -- two-stage valid/ready ALU pipeline with accumulator.
//   clk, rst_n      : clock, asynchronous active-low reset
//   in_valid/ready  : input handshake for operand set a, b, op
//   out_valid/ready : output handshake for result, zero, error
//   result          : WIDTH+1 result (MSB carry/borrow/shift-out)
//   zero            : result[WIDTH-1:0] == 0
//   error           : signed overflow of the presented result
//   error_sticky    : OR of error since reset or last clr_err
//   clr_err         : synchronous clear of error_sticky (a new error wins)
// S1 registers the operand set, S2 registers the computed result. The
// accumulator changes only on the edge an ACC/CLRACC set loads into S2.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   result,
  output logic             zero,
  output logic             error,
  output logic             error_sticky,
  input  logic             clr_err
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  op_t              s1_op_q, s1_op_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH:0]   result_q, result_d;
  logic             zero_q, zero_d;
  logic             error_q, error_d;
  logic             sticky_q, sticky_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic             s2_free;
  logic             s2_load;
  logic             in_fire;

  logic [WIDTH:0]   core_result;
  logic             core_error;
  logic             core_acc_load;
  logic [WIDTH-1:0] core_acc_next;

  alu_core #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_core (
    .a        (s1_a_q),
    .b        (s1_b_q),
    .op       (s1_op_q),
    .acc      (acc_q),
    .result   (core_result),
    .error    (core_error),
    .acc_load (core_acc_load),
    .acc_next (core_acc_next)
  );

  always_comb begin
    // S2 can take a new entry when empty or when its entry leaves this cycle.
    s2_free  = !s2_valid_q || out_ready;
    s2_load  = s1_valid_q && s2_free;
    in_ready = !s1_valid_q || s2_free;
    in_fire  = in_valid && in_ready;

    s1_valid_d = in_fire || (s1_valid_q && !s2_free);
    s1_a_d     = in_fire ? a : s1_a_q;
    s1_b_d     = in_fire ? b : s1_b_q;
    s1_op_d    = in_fire ? op_t'(op) : s1_op_q;

    s2_valid_d = s2_free ? s1_valid_q : s2_valid_q;
    result_d   = s2_load ? core_result : result_q;
    zero_d     = s2_load ? (core_result[WIDTH-1:0] == '0) : zero_q;
    error_d    = s2_load ? core_error : error_q;

    acc_d = (s2_load && core_acc_load) ? core_acc_next : acc_q;

    // Set has priority over clear so an error is never lost.
    if (s2_load && core_error) begin
      sticky_d = 1'b1;
    end else if (clr_err) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= OP_ADD;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      error_q    <= 1'b0;
      sticky_q   <= 1'b0;
      acc_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_op_q    <= s1_op_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      error_q    <= error_d;
      sticky_q   <= sticky_d;
      acc_q      <= acc_d;
    end
  end

  assign out_valid    = s2_valid_q;
  assign result       = result_q;
  assign zero         = zero_q;
  assign error        = error_q;
  assign error_sticky = sticky_q;

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [2:0]    op = 3'd0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W:0]    result;
  logic          zero;
  logic          error;
  logic          error_sticky;
  logic          clr_err = 1'b0;

  int checks = 0;
  int errors = 0;

  // stimulus queue and captured outputs for run_stream
  logic [2:0]    q_op [16];
  logic [W-1:0]  q_a [16];
  logic [W-1:0]  q_b [16];
  logic [W:0]    r_res [16];
  logic          r_zero [16];
  logic          r_err [16];
  logic          r_sticky [16];
  int            n_r;
  int            first_lat;
  int            cycles_used;
  logic          timed_out;

  alu_pipe #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a            (a),
    .b            (b),
    .op           (op),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .zero         (zero),
    .error        (error),
    .error_sticky (error_sticky),
    .clr_err      (clr_err)
  );

  always #5 clk = ~clk;

  task automatic set_q(input int i, input logic [2:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y);
    q_op[i] = o;
    q_a[i]  = x;
    q_b[i]  = y;
  endtask

  // Streams n queued sets; mode 0 holds out_ready high, mode 1 toggles it.
  task automatic run_stream(input int n, input int mode, input logic clr);
    int idx = 0;
    int cyc = 0;
    int acc_first = 0;
    n_r = 0;
    first_lat = -1;
    while ((idx < n || n_r < n) && cyc < 80) begin
      @(negedge clk);
      out_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      clr_err = clr;
      if (idx < n) begin
        in_valid = 1'b1;
        op = q_op[idx];
        a  = q_a[idx];
        b  = q_b[idx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        r_res[n_r]    = result;
        r_zero[n_r]   = zero;
        r_err[n_r]    = error;
        r_sticky[n_r] = error_sticky;
        if (n_r == 0) first_lat = cyc - acc_first;
        n_r++;
      end
      if (in_valid && in_ready) begin
        if (idx == 0) acc_first = cyc;
        idx++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    clr_err = 1'b0;
    cycles_used = cyc;
    timed_out = (n_r < n);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== '0 || zero !== 1'b0 || error !== 1'b0 ||
        error_sticky !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b result=%h zero=%b err=%b sticky=%b required 0/0/0/0/0",
               out_valid, result, zero, error, error_sticky);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    $display("test_reset done");
  endtask

  task automatic test_add();
    set_q(0, OP_ADD, 16'h0001, 16'h0001);
    run_stream(1, 0, 1'b0);
    checks++;
    if (timed_out) begin
      errors++;
      $display("FAIL add_timeout: got %0d results required 1", n_r);
    end
    checks++;
    if (first_lat != 2) begin
      errors++;
      $display("FAIL add_latency: got %0d required 2", first_lat);
    end
    checks++;
    if (r_res[0] !== 17'h00002 || r_zero[0] !== 1'b0 || r_err[0] !== 1'b0) begin
      errors++;
      $display("FAIL add_1_1: got result=%h zero=%b err=%b required 00002/0/0",
               r_res[0], r_zero[0], r_err[0]);
    end
    $display("test_add: 1+1 -> %h", r_res[0]);
  endtask

  task automatic test_overflow();
    set_q(0, OP_ADD, 16'h7FFF, 16'h0001);
    set_q(1, OP_ADD, 16'hFFFF, 16'h0001);
    run_stream(2, 0, 1'b0);
    checks++;
    if (r_res[0] !== 17'h08000 || r_err[0] !== 1'b1 || r_sticky[0] !== 1'b1) begin
      errors++;
      $display("FAIL add_ovf: got result=%h err=%b sticky=%b required 08000/1/1",
               r_res[0], r_err[0], r_sticky[0]);
    end
    checks++;
    if (r_res[1] !== 17'h10000 || r_zero[1] !== 1'b1 || r_err[1] !== 1'b0) begin
      errors++;
      $display("FAIL add_carry: got result=%h zero=%b err=%b required 10000/1/0",
               r_res[1], r_zero[1], r_err[1]);
    end
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    #1;
    checks++;
    if (error_sticky !== 1'b0) begin
      errors++;
      $display("FAIL clr_err: got sticky=%b required 0", error_sticky);
    end
    // clr_err held high while an overflowing result loads: the set must win.
    set_q(0, OP_ADD, 16'h7FFF, 16'h0001);
    run_stream(1, 0, 1'b1);
    checks++;
    if (r_sticky[0] !== 1'b1) begin
      errors++;
      $display("FAIL sticky_set_wins: got %b required 1", r_sticky[0]);
    end
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    $display("test_overflow done");
  endtask

  task automatic test_sub_logic();
    logic [W:0] exp_r [6];
    logic       exp_e [6];
    set_q(0, OP_SUB, 16'h0005, 16'h0003); exp_r[0] = 17'h00002; exp_e[0] = 1'b0;
    set_q(1, OP_SUB, 16'h0003, 16'h0005); exp_r[1] = 17'h1FFFE; exp_e[1] = 1'b0;
    set_q(2, OP_SUB, 16'h8000, 16'h0001); exp_r[2] = 17'h07FFF; exp_e[2] = 1'b1;
    set_q(3, OP_AND, 16'hF0F0, 16'hFF00); exp_r[3] = 17'h0F000; exp_e[3] = 1'b0;
    set_q(4, OP_OR,  16'hF0F0, 16'hFF00); exp_r[4] = 17'h0FFF0; exp_e[4] = 1'b0;
    set_q(5, OP_XOR, 16'hF0F0, 16'hFF00); exp_r[5] = 17'h00FF0; exp_e[5] = 1'b0;
    run_stream(6, 0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (r_res[i] !== exp_r[i] || r_err[i] !== exp_e[i]) begin
        errors++;
        $display("FAIL sub_logic[%0d]: got result=%h err=%b required %h/%b",
                 i, r_res[i], r_err[i], exp_r[i], exp_e[i]);
      end else begin
        $display("sub_logic[%0d] op=%0d -> %h", i, q_op[i], r_res[i]);
      end
    end
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic test_shl();
    set_q(0, OP_SHL, 16'h8001, 16'h0001);
    set_q(1, OP_SHL, 16'h8001, 16'h0010);
    set_q(2, OP_SHL, 16'h0003, 16'h0004);
    run_stream(3, 0, 1'b0);
    checks++;
    if (r_res[0] !== 17'h10002) begin
      errors++;
      $display("FAIL shl_1: got %h required 10002", r_res[0]);
    end
    checks++;
    if (r_res[1][W-1:0] !== 16'h0000 || r_zero[1] !== 1'b1) begin
      errors++;
      $display("FAIL shl_16: got low=%h zero=%b required 0000/1", r_res[1][W-1:0], r_zero[1]);
    end
    checks++;
    if (r_res[2] !== 17'h00030) begin
      errors++;
      $display("FAIL shl_4: got %h required 00030", r_res[2]);
    end
    $display("test_shl: %h %h %h", r_res[0], r_res[1], r_res[2]);
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; op = OP_ADD; a = 16'd1; b = 16'd1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready0: got %b required 1", in_ready); end
    @(negedge clk);
    a = 16'd2; b = 16'd2;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1: got %b required 1", in_ready); end
    @(negedge clk);
    a = 16'd3; b = 16'd3;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== 17'd2) begin
      errors++;
      $display("FAIL bp_full: got ready=%b valid=%b result=%h required 0/1/00002",
               in_ready, out_valid, result);
    end
    repeat (2) begin
      @(negedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b0 || result !== 17'd2) begin
        errors++;
        $display("FAIL bp_hold: got ready=%b result=%h required 0/00002", in_ready, result);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || result !== 17'd2) begin
      errors++;
      $display("FAIL bp_release: got ready=%b result=%h required 1/00002", in_ready, result);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || result !== 17'd4) begin
      errors++;
      $display("FAIL bp_second: got valid=%b result=%h required 1/00004", out_valid, result);
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || result !== 17'd6) begin
      errors++;
      $display("FAIL bp_third: got valid=%b result=%h required 1/00006", out_valid, result);
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: got valid=%b required 0", out_valid);
    end
    $display("test_backpressure done");
  endtask

  task automatic test_acc();
    logic [W:0] exp_r [6];
    logic       exp_e [6];
    logic       exp_z [6];
    set_q(0, OP_CLRACC, 16'h1234, 16'h0000); exp_r[0] = 17'h00000; exp_e[0] = 0; exp_z[0] = 1;
    set_q(1, OP_ACC,    16'h0005, 16'h0000); exp_r[1] = 17'h00005; exp_e[1] = 0; exp_z[1] = 0;
    set_q(2, OP_ACC,    16'h0007, 16'h0000); exp_r[2] = 17'h0000C; exp_e[2] = 0; exp_z[2] = 0;
    set_q(3, OP_ACC,    16'h0000, 16'h0000); exp_r[3] = 17'h0000C; exp_e[3] = 0; exp_z[3] = 0;
    set_q(4, OP_ACC,    16'h7FF4, 16'h0000); exp_r[4] = 17'h08000; exp_e[4] = 1; exp_z[4] = 0;
    set_q(5, OP_CLRACC, 16'h0000, 16'h0000); exp_r[5] = 17'h00000; exp_e[5] = 0; exp_z[5] = 1;
    run_stream(6, 1, 1'b0);
    checks++;
    if (timed_out) begin
      errors++;
      $display("FAIL acc_timeout: got %0d results required 6", n_r);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (r_res[i] !== exp_r[i] || r_err[i] !== exp_e[i] || r_zero[i] !== exp_z[i]) begin
        errors++;
        $display("FAIL acc[%0d]: got result=%h err=%b zero=%b required %h/%b/%b",
                 i, r_res[i], r_err[i], r_zero[i], exp_r[i], exp_e[i], exp_z[i]);
      end else begin
        $display("acc[%0d] op=%0d a=%h -> %h", i, q_op[i], q_a[i], r_res[i]);
      end
    end
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) set_q(i, OP_ADD, W'(i * 3), W'(100));
    run_stream(8, 0, 1'b0);
    checks++;
    if (cycles_used != 10) begin
      errors++;
      $display("FAIL b2b_throughput: got %0d cycles required 10", cycles_used);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (r_res[i] !== (W + 1)'(i * 3 + 100)) begin
        errors++;
        $display("FAIL b2b[%0d]: got %h required %h", i, r_res[i], (W + 1)'(i * 3 + 100));
      end
    end
    $display("test_back_to_back: 8 results in %0d cycles", cycles_used);
  endtask

  task automatic test_reset_midstream();
    logic stale = 1'b0;
    set_q(0, OP_ACC, 16'h0009, 16'h0000);
    set_q(1, OP_ADD, 16'h7FFF, 16'h7FFF);
    run_stream(2, 0, 1'b0);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; op = OP_ADD; a = 16'd1; b = 16'd1;
    @(negedge clk);
    a = 16'd2; b = 16'd2;
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || error_sticky !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre: got valid=%b sticky=%b required 1/1", out_valid, error_sticky);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== '0 || error_sticky !== 1'b0) begin
      errors++;
      $display("FAIL midreset_clear: got valid=%b result=%h sticky=%b required 0/00000/0",
               out_valid, result, error_sticky);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_ready: got %b required 1", in_ready);
    end
    repeat (4) begin
      @(negedge clk);
      #1;
      if (out_valid !== 1'b0) stale = 1'b1;
    end
    checks++;
    if (stale !== 1'b0) begin
      errors++;
      $display("FAIL midreset_stale: got out_valid during idle required none");
    end
    // accumulator must have been cleared by reset
    set_q(0, OP_ACC, 16'h0000, 16'h0000);
    run_stream(1, 0, 1'b0);
    checks++;
    if (r_res[0] !== 17'h00000) begin
      errors++;
      $display("FAIL midreset_acc: got %h required 00000", r_res[0]);
    end
    $display("test_reset_midstream done");
  endtask

  initial begin
    test_reset();
    test_add();
    test_overflow();
    test_sub_logic();
    test_shl();
    test_backpressure();
    test_acc();
    test_back_to_back();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
